// File: rtl/dfe_pkg.sv
// Shared DFE definitions: sample width, matched decimation/interpolation factors,
// counter widths and the rate-change FSM state encoding.
package dfe_pkg;

    localparam int DATA_BW       = 8;
    localparam int DECIM_FACTOR  = 250;
    localparam int INTERP_FACTOR = 250;

    // A factor of 1 still needs a one-bit counter so the last flag has something to compare.
    function automatic int cnt_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DECIM_CNT_BW  = cnt_bw(DECIM_FACTOR);
    localparam int INTERP_CNT_BW = cnt_bw(INTERP_FACTOR);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/interpolator_if.sv
// Valid/ready sample stream; the producer uses master, the consumer uses slave.
interface interpolator_if #(
    parameter int DATA_BW = dfe_pkg::DATA_BW
) ();

    logic               valid;
    logic               ready;
    logic [DATA_BW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/beat_counter.sv
// Mod-N counter with clear, increment-enable and a last-count flag; wraps to zero
// when incremented on the last count.
module beat_counter #(
    parameter int N      = 4,
    parameter int CNT_BW = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [CNT_BW-1:0] cnt_o,
    output logic              last_o
);

    logic [CNT_BW-1:0] cnt_q;
    logic [CNT_BW-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_BW'(N - 1));
    assign cnt_o  = cnt_q;

    // Next count: clear wins over increment, increment wraps at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_BW{1'b0}};
        end else if (inc_i) begin
            cnt_d = last_o ? {CNT_BW{1'b0}} : cnt_q + CNT_BW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_BW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interpolator_chk.sv
// Invariant checks for the interpolator beat counter.
module interpolator_chk #(
    parameter int N      = 4,
    parameter int CNT_BW = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic [CNT_BW-1:0] cnt_i
);

    cnt_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i) int'(cnt_i) < N);

endmodule

// File: rtl/interpolator.sv
// Sample-rate expander: each accepted input sample becomes INTERP_FACTOR output beats,
// either zero-stuffed (sample then zeros) or held (sample repeated).
module interpolator #(
    parameter int DATA_BW       = dfe_pkg::DATA_BW,
    parameter int INTERP_FACTOR = dfe_pkg::INTERP_FACTOR
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           mode_hold_i,
    interpolator_if.slave  in_if,
    interpolator_if.master out_if
);

    import dfe_pkg::*;

    localparam int COUNTER_BW = cnt_bw(INTERP_FACTOR);

    state_e                  state_q;
    state_e                  state_d;
    logic [DATA_BW-1:0]      hold_q;
    logic [DATA_BW-1:0]      hold_d;
    logic                    mode_q;
    logic                    mode_d;
    logic [COUNTER_BW-1:0]   cnt_s;
    logic                    last_s;
    logic                    in_fire_s;
    logic                    out_fire_s;
    logic                    valid_s;

    assign valid_s    = (state_q == EMIT);
    assign out_fire_s = valid_s & out_if.ready;
    // Ready also opens on the final beat so the next sample follows with no bubble.
    assign in_if.ready = en_i & ~rst_i & ((state_q == IDLE) | (out_fire_s & last_s));
    assign in_fire_s  = in_if.valid & in_if.ready;

    assign out_if.valid = valid_s;
    assign out_if.data  = (valid_s && (mode_q || (cnt_s == {COUNTER_BW{1'b0}})))
                          ? hold_q : {DATA_BW{1'b0}};

    beat_counter #(
        .N      (INTERP_FACTOR),
        .CNT_BW (COUNTER_BW)
    ) u_beat_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (~en_i),
        .inc_i  (out_fire_s),
        .cnt_o  (cnt_s),
        .last_o (last_s)
    );

    // Next-state for the FSM and the captured sample; disable discards any sample in flight.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        if (!en_i) begin
            state_d = IDLE;
            hold_d  = {DATA_BW{1'b0}};
            mode_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire_s) begin
                        hold_d  = in_if.data;
                        mode_d  = mode_hold_i;
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EMIT: begin
                    if (out_fire_s && last_s) begin
                        if (in_fire_s) begin
                            hold_d  = in_if.data;
                            mode_d  = mode_hold_i;
                            state_d = EMIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = EMIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and sample registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= {DATA_BW{1'b0}};
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
        end
    end

    interpolator_chk #(
        .N      (INTERP_FACTOR),
        .CNT_BW (COUNTER_BW)
    ) u_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cnt_i (cnt_s)
    );

endmodule

// File: tb/tb_interpolator.sv
// Bench for interpolator with INTERP_FACTOR=4: directed cycle tables, hand-written
// enable-drop and mid-stream reset sequences, then randomised traffic against a beat-queue model.
module tb_interpolator;

    localparam int DW = 8;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interpolator_if #(.DATA_BW(DW)) in_if ();
    interpolator_if #(.DATA_BW(DW)) out_if ();

    interpolator #(
        .DATA_BW       (DW),
        .INTERP_FACTOR (N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .mode_hold_i (mode),
        .in_if       (in_if.slave),
        .out_if      (out_if.master)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic          v;
        logic          m;
        logic [DW-1:0] d;
        logic          r;
        logic          er;
        logic          ev;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic a_rst, input logic a_en, input logic a_v, input logic a_m,
                                input logic [DW-1:0] a_d, input logic a_r,
                                input logic a_er, input logic a_ev, input logic [DW-1:0] a_ed);
        vec_t t;
        t.rst = a_rst; t.en = a_en; t.v = a_v; t.m = a_m; t.d = a_d; t.r = a_r;
        t.er = a_er; t.ev = a_ev; t.ed = a_ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, then let the edge commit.
    task automatic step(input vec_t t, input string nm);
        rst = t.rst; en = t.en; in_if.valid = t.v; mode = t.m; in_if.data = t.d; out_if.ready = t.r;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(in_if.ready), 32'(t.er));
        chk({nm, "_valid"}, 32'(out_if.valid), 32'(t.ev));
        chk({nm, "_data"}, 32'(out_if.data), 32'(t.ed));
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of beats still owed for the sample in flight.
    logic [DW-1:0] q[$];
    logic          src_v = 1'b0;
    logic          src_m = 1'b0;
    logic [DW-1:0] src_d = 8'h00;
    int accepted  = 0;
    int beats     = 0;
    int discarded = 0;

    task automatic rand_cycle(input logic en_v, input logic r);
        logic exp_v;
        logic exp_r;
        logic [DW-1:0] exp_d;
        rst = 1'b0; en = en_v; in_if.valid = src_v; in_if.data = src_d; mode = src_m; out_if.ready = r;
        exp_v = (q.size() > 0);
        exp_r = en_v && ((q.size() == 0) || (q.size() == 1 && r));
        exp_d = exp_v ? q[0] : 8'h00;
        @(negedge clk);
        chk("rnd_valid", 32'(out_if.valid), 32'(exp_v));
        chk("rnd_ready", 32'(in_if.ready), 32'(exp_r));
        chk("rnd_data", 32'(out_if.data), 32'(exp_d));
        if (exp_v && r) begin
            void'(q.pop_front());
            beats++;
        end
        if (!en_v) begin
            discarded += q.size();
            q.delete();
        end else if (src_v && exp_r) begin
            accepted++;
            q.push_back(src_d);
            for (int k = 1; k < N; k++) q.push_back(src_m ? src_d : 8'h00);
            src_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0;
        in_if.valid = 1'b1; in_if.data = 8'hAA; out_if.ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with traffic offered.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00));
        // Zero-stuff, back-to-back samples 5A and C3.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h5A));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC3));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00));
        // Hold mode 7F with a five-cycle stall on the second beat.
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7F));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7F));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7F));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7F));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h7F));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Enable drop after two beats of 11, then a clean 22.
        step(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00), "en_acc11");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11), "en_b0");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00), "en_b1");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00), "en_drop");
        step(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00), "en_acc22");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22), "en22_b0");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00), "en22_b1");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00), "en22_b2");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00), "en22_b3");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00), "en22_idle");

        // Reset pulse on the third beat of held sample 33, then held sample 44 from beat 0.
        step(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00), "mr_acc33");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33), "mr_b0");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33), "mr_b1");
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33), "mr_rst");
        step(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00), "mr_acc44");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44), "mr44_b0");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44), "mr44_b1");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44), "mr44_b2");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44), "mr44_b3");
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00), "mr44_idle");

        // Randomised traffic; the source holds its sample until accepted.
        for (int c = 0; c < 10000; c++) begin
            if (!src_v && $urandom_range(0, 2) == 0) begin
                src_v = 1'b1;
                src_d = 8'($urandom);
                src_m = 1'($urandom_range(0, 1));
            end
            rand_cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0));
        end
        src_v = 1'b0;
        for (int c = 0; c < N + 2; c++) rand_cycle(1'b1, 1'b1);

        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_beat_total", 32'(beats + discarded), 32'(N * accepted));
        chk("rnd_enough_samples", 32'(accepted > 500), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interpolator.md
Name: interpolator

Overview:
- Sample-rate expander for the DFE; the inverse of the decimator.
- Accepts one DATA_BW sample per input handshake and emits INTERP_FACTOR output beats for it.
- Two output modes: zero-stuffing (sample then zeros) or sample-and-hold (sample repeated).
- Feeds DAC/test-tone paths and loopback checks of the decimation chain.
- Valid/ready on both sides, so it can throttle its source and absorb downstream stalls.

Parameters:
- DATA_BW, 8, sample width in bits.
- INTERP_FACTOR, 250, output beats per input sample; legal range >= 1.
- COUNTER_BW, $clog2(INTERP_FACTOR) (minimum 1), beat counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  block enable; low acts as a synchronous clear.
- mode_hold_i  input  1  1 = sample-and-hold, 0 = zero-stuff; sampled at input acceptance.
- data_i  input  DATA_BW  input sample.
- valid_i  input  1  input sample valid.
- ready_o  output  1  block can accept an input sample this cycle.
- data_o  output  DATA_BW  output beat data.
- valid_o  output  1  output beat valid.
- ready_i  input  1  downstream accepts the beat this cycle.

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high.
- Registers:
  - hold_q[DATA_BW], cleared to 0.
  - mode_q, cleared to 0.
  - cnt_q[COUNTER_BW], cleared to 0.
  - state: IDLE or EMIT, cleared to IDLE.
- Reset values: if rst_i or !en_i at a clock edge, all registers return to reset values. Any in-flight sample is discarded, with no further beats. rst_i has priority.
- Outputs after reset: valid_o=0, data_o=0, ready_o=0 while en_i=0, ready_o=1 in IDLE once en_i=1.
- Derived signals:
  - out_fire = valid_o & ready_i.
  - last = (cnt_q == INTERP_FACTOR-1).
  - in_fire = valid_i & ready_o.
- ready_o = en_i & (state==IDLE | (out_fire & last)). This is combinational from ready_i and permits back-to-back samples with no bubble.
- valid_o = (state==EMIT). It must not depend on valid_i.
- data_o = (mode_q | cnt_q==0) ? hold_q : 0. data_o is 0 whenever valid_o=0.
- IDLE:
  - in_fire -> hold_q<=data_i, mode_q<=mode_hold_i, cnt_q<=0, go to EMIT.
- EMIT:
  - out_fire & !last -> cnt_q<=cnt_q+1.
  - out_fire & last & in_fire -> reload hold_q and mode_q, cnt_q<=0, stay in EMIT.
  - out_fire & last & !in_fire -> cnt_q<=0, go to IDLE.
  - !out_fire -> hold all state. Stall of any length; beat data and count are preserved.
- Latency: sample accepted at edge t gives its first beat valid in the cycle after edge t.
- Throughput: with ready_i=1 continuously, exactly INTERP_FACTOR beats per sample, and exactly one accepted sample per INTERP_FACTOR cycles at steady state.
- INTERP_FACTOR=1: last is always true. The block is a one-entry pipeline register; mode has no effect.
- Wrap-around: cnt_q never exceeds INTERP_FACTOR-1. Assertion: cnt_q < INTERP_FACTOR at all times.
- Input/output stability: the input side must hold data_i/valid_i stable until ready_o. Once valid_o is high, data_o/valid_o stay stable until ready_i.

Decomposition:
- Shared package dfe_pkg holds:
  - DATA_BW.
  - DECIM_FACTOR and INTERP_FACTOR (both 250, a matched pair).
  - The derived counter widths.
  - The state encoding constants (IDLE=1'b0, EMIT=1'b1).
- One natural sub-module: beat_counter. It is a mod-N counter with clear, increment-enable and a last flag, and is reusable by a later decimator revision. All other logic stays inline.

Test Plan (bench overrides INTERP_FACTOR=4):
- Reset: hold rst_i=1 for 3 cycles with valid_i=1, en_i=1 -> valid_o=0, data_o=0, ready_o=0 throughout; after release ready_o=1.
- Zero-stuff: mode 0, samples 0x5A then 0xC3 back-to-back, ready_i=1 -> data_o sequence 5A,00,00,00,C3,00,00,00. ready_o is high on cycles 0 and 4 only; no bubble between samples.
- Hold mode with stall: mode 1, sample 0x7F, ready_i low on the 2nd beat for 5 cycles -> four beats of 7F, cnt_q frozen during the stall, ready_o low until the 4th beat fires.
- Enable drop: en_i=0 after beat 2 of sample 0x11 -> next cycle valid_o=0, state IDLE. Re-enable with sample 0x22 -> four clean beats, first beat 22, no leftover 11 beats.
- Mid-stream reset: rst_i pulse during EMIT beat 3 -> valid_o=0 on the next cycle, cnt_q=0, hold_q=0; the next sample emits from beat 0.
- Randomised ready_i/valid_i for 10k cycles: scoreboard checks output count = 4 x accepted samples and the per-mode data pattern.
